// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
//
// Dcache-side store write buffer. It accepts full 64-bit dword stores from
// retire, queues them in a circular FIFO, merges back-to-back stores to the
// same dword, drains them in order to the memory bus under an arbiter grant,
// and forwards buffered data to younger loads.
//
// Handshake: memory accepts the command in any cycle where this block drives
// BUS_STORE (which it only does while mem_grant is high) and mem2proc_response
// is non-zero. That cycle pops the head. A granted cycle with a zero response
// is a rejection and costs one BACKOFF cycle before the same head re-issues.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   store_en              retire commits a dword store this cycle
//   store2Dcache_addr     store dword address (bits [2:0] ignored)
//   store2Dcache_data     store dword data
//   sb_full, sb_empty     registered occupancy flags (count after the edge)
//   overflow              sticky: a store was dropped on a full buffer
//   load_lookup_valid     load probe strobe
//   load_lookup_addr      load address, matched on bits [XLEN-1:3]
//   load_fwd_hit          combinational forward hit
//   load_fwd_data         forwarded dword (0 on miss)
//   mem_grant             bus granted to this block this cycle
//   mem2proc_response     non-zero: memory accepted this cycle's command
//   proc2mem_command      BUS_STORE or BUS_NONE
//   proc2mem_addr         head address, bits [2:0] = 0 (0 when idle)
//   proc2mem_data         head data (0 when idle)
//   fsm_state             debug: drain FSM state (IDLE=0, ISSUE=1, BACKOFF=2)
//   entry_count           debug: number of valid entries
// -----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          store_en,
    input  logic [XLEN-1:0]               store2Dcache_addr,
    input  logic [63:0]                   store2Dcache_data,
    output logic                          sb_full,
    output logic                          sb_empty,
    output logic                          overflow,
    input  logic                          load_lookup_valid,
    input  logic [XLEN-1:0]               load_lookup_addr,
    output logic                          load_fwd_hit,
    output logic [63:0]                   load_fwd_data,
    input  logic                          mem_grant,
    input  logic [3:0]                    mem2proc_response,
    output logic [1:0]                    proc2mem_command,
    output logic [XLEN-1:0]               proc2mem_addr,
    output logic [63:0]                   proc2mem_data,
    output logic [1:0]                    fsm_state,
    output logic [$clog2(DEPTH):0]        entry_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = XLEN - 3;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BACKOFF = 2'd2
    } drain_state_t;

    drain_state_t     state, state_next;

    logic [TAG_W-1:0] entry_addr [DEPTH];
    logic [63:0]      entry_data [DEPTH];
    logic [PTR_W-1:0] head, tail, youngest;
    logic [CNT_W-1:0] count, count_next;

    logic [TAG_W-1:0] store_tag, lookup_tag;
    logic             issue_go, pop, coalesce, alloc, drop;
    logic             buffer_full;

    logic             fwd_hit_raw;
    logic [63:0]      fwd_data_raw;
    logic [PTR_W-1:0] fwd_idx;

    // Address low bits select a byte within the dword and are irrelevant here.
    logic unused_low_bits;
    assign unused_low_bits = ^{store2Dcache_addr[2:0], load_lookup_addr[2:0]};

    assign store_tag   = store2Dcache_addr[XLEN-1:3];
    assign lookup_tag  = load_lookup_addr[XLEN-1:3];
    assign youngest    = tail - PTR_W'(1);
    assign buffer_full = (count == CNT_W'(DEPTH));

    assign fsm_state   = state;
    assign entry_count = count;

    // ---------------------------------------------------------------------
    // Push / pop / coalesce decisions
    // ---------------------------------------------------------------------
    // Reset kills any in-flight command in the same cycle, so a granted
    // issue never counts as accepted while reset is high.
    assign issue_go = (state == ISSUE) && mem_grant && !reset;
    assign pop      = issue_go && (mem2proc_response != 4'd0);

    // Merging into a head that memory is taking this cycle would lose the
    // new data, so that case falls through to a normal allocation.
    assign coalesce = store_en && (count != '0)
                      && (entry_addr[youngest] == store_tag)
                      && !(pop && (youngest == head));
    assign alloc    = store_en && !coalesce && (!buffer_full || pop);
    assign drop     = store_en && !coalesce && buffer_full && !pop;

    assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);

    // ---------------------------------------------------------------------
    // State register and storage
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sb_full  <= 1'b0;
            sb_empty <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (coalesce) begin
                entry_data[youngest] <= store2Dcache_data;
            end
            if (alloc) begin
                entry_addr[tail] <= store_tag;
                entry_data[tail] <= store2Dcache_data;
                tail             <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count    <= count_next;
            sb_full  <= (count_next == CNT_W'(DEPTH));
            sb_empty <= (count_next == '0);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Drain FSM: next state and bus outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;

        case (state)
            // Looking at the post-edge count lets a store pushed this cycle
            // reach the bus on the very next cycle.
            IDLE: begin
                if (count_next != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_go) begin
                    if (pop) begin
                        if (count_next == '0) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                state_next = ISSUE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (issue_go) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = {entry_addr[head], 3'b000};
            proc2mem_data    = entry_data[head];
        end
    end

    // ---------------------------------------------------------------------
    // Load forwarding: walk oldest to youngest so the youngest match wins,
    // then let a same-cycle incoming store override everything.
    // ---------------------------------------------------------------------
    always_comb begin
        fwd_hit_raw  = 1'b0;
        fwd_data_raw = '0;
        fwd_idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entry_addr[fwd_idx] == lookup_tag)) begin
                fwd_hit_raw  = 1'b1;
                fwd_data_raw = entry_data[fwd_idx];
            end
        end
        if (store_en && (store_tag == lookup_tag)) begin
            fwd_hit_raw  = 1'b1;
            fwd_data_raw = store2Dcache_data;
        end
    end

    assign load_fwd_hit  = load_lookup_valid && !reset && fwd_hit_raw;
    assign load_fwd_data = load_fwd_hit ? fwd_data_raw : 64'd0;

endmodule

// File: tb/tb_store_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_write_buffer
//
// Directed bench for store_write_buffer (DEPTH=4, XLEN=32). Inputs change one
// time unit after the rising edge; outputs are sampled two time units after
// the edge, well clear of the next one.
// -----------------------------------------------------------------------------
module tb_store_write_buffer;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;

    logic        clock;
    logic        reset;
    logic        store_en;
    logic [31:0] store2Dcache_addr;
    logic [63:0] store2Dcache_data;
    logic        sb_full, sb_empty, overflow;
    logic        load_lookup_valid;
    logic [31:0] load_lookup_addr;
    logic        load_fwd_hit;
    logic [63:0] load_fwd_data;
    logic        mem_grant;
    logic [3:0]  mem2proc_response;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  fsm_state;
    logic [2:0]  entry_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];

    store_write_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .store_en          (store_en),
        .store2Dcache_addr (store2Dcache_addr),
        .store2Dcache_data (store2Dcache_data),
        .sb_full           (sb_full),
        .sb_empty          (sb_empty),
        .overflow          (overflow),
        .load_lookup_valid (load_lookup_valid),
        .load_lookup_addr  (load_lookup_addr),
        .load_fwd_hit      (load_fwd_hit),
        .load_fwd_data     (load_fwd_data),
        .mem_grant         (mem_grant),
        .mem2proc_response (mem2proc_response),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .fsm_state         (fsm_state),
        .entry_count       (entry_count)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_store(input logic en, input logic [31:0] a, input logic [63:0] d);
        store_en          = en;
        store2Dcache_addr = a;
        store2Dcache_data = d;
    endtask

    task automatic drive_probe(input logic v, input logic [31:0] a);
        load_lookup_valid = v;
        load_lookup_addr  = a;
    endtask

    task automatic drive_mem(input logic g, input logic [3:0] r);
        mem_grant         = g;
        mem2proc_response = r;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", sb_empty); end
        n_cmp++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", sb_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_NONE, 32'd0, 64'd0}) begin
            n_fail++; $display("FAIL reset_bus: got cmd %0d addr %h data %h want 0/0/0", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b0, 64'd0}) begin
            n_fail++; $display("FAIL reset_fwd: got hit %b data %h want 0/0", load_fwd_hit, load_fwd_data);
        end
        n_cmp++; if ({fsm_state, entry_count} !== {S_IDLE, 3'd0}) begin
            n_fail++; $display("FAIL reset_state: got state %0d count %0d want 0/0", fsm_state, entry_count);
        end
    endtask

    task automatic test_basic_push();
        drive_mem(1'b1, 4'd1);
        drive_store(1'b1, 32'h100, 64'h1122334455667788);
        #1;
        n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL basic_cycle_t_cmd: got %0d want %0d", proc2mem_command, BUS_NONE); end
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        #1;
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_STORE, 32'h100, 64'h1122334455667788}) begin
            n_fail++; $display("FAIL basic_issue: got cmd %0d addr %h data %h want 2/100/1122334455667788", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick();
        #1;
        n_cmp++; if ({sb_empty, fsm_state, proc2mem_command} !== {1'b1, S_IDLE, BUS_NONE}) begin
            n_fail++; $display("FAIL basic_drained: got empty %b state %0d cmd %0d want 1/0/0", sb_empty, fsm_state, proc2mem_command);
        end
    endtask

    // Head being accepted must not absorb a same-address store: two stores go out.
    task automatic test_back_to_back();
        drive_mem(1'b1, 4'd1);
        drive_store(1'b1, 32'h500, 64'h1);
        tick();
        drive_store(1'b1, 32'h500, 64'h2);
        #1;
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_STORE, 32'h500, 64'h1}) begin
            n_fail++; $display("FAIL b2b_first: got cmd %0d addr %h data %h want 2/500/1", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        #1;
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_STORE, 32'h500, 64'h2}) begin
            n_fail++; $display("FAIL b2b_second: got cmd %0d addr %h data %h want 2/500/2", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick();
        #1;
        n_cmp++; if ({proc2mem_command, sb_empty} !== {BUS_NONE, 1'b1}) begin
            n_fail++; $display("FAIL b2b_done: got cmd %0d empty %b want 0/1", proc2mem_command, sb_empty);
        end
    endtask

    task automatic test_coalesce();
        int stores;
        stores = 0;
        drive_mem(1'b0, 4'd0);
        drive_store(1'b1, 32'h200, 64'hA);
        tick();
        drive_store(1'b1, 32'h204, 64'hB);
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        drive_probe(1'b1, 32'h200);
        #1;
        n_cmp++; if (entry_count !== 3'd1) begin n_fail++; $display("FAIL coalesce_count: got %0d want 1", entry_count); end
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b1, 64'hB}) begin
            n_fail++; $display("FAIL coalesce_fwd: got hit %b data %h want 1/b", load_fwd_hit, load_fwd_data);
        end
        n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL coalesce_nogrant_cmd: got %0d want 0", proc2mem_command); end
        drive_probe(1'b0, 32'h0);
        tick();
        drive_mem(1'b1, 4'd1);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (proc2mem_command === BUS_STORE) begin
                stores++;
                n_cmp++; if ({proc2mem_addr, proc2mem_data} !== {32'h200, 64'hB}) begin
                    n_fail++; $display("FAIL coalesce_store: got addr %h data %h want 200/b", proc2mem_addr, proc2mem_data);
                end
            end
            tick();
        end
        n_cmp++; if (stores != 1) begin n_fail++; $display("FAIL coalesce_store_count: got %0d want 1", stores); end
        drive_mem(1'b0, 4'd0);
    endtask

    task automatic test_full_overflow();
        do_reset();
        drive_mem(1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            drive_store(1'b1, 32'h1000 + 32'(i * 8), 64'(i + 1));
            tick();
        end
        drive_store(1'b0, 32'h0, 64'h0);
        #1;
        n_cmp++; if ({sb_full, overflow, entry_count} !== {1'b1, 1'b0, 3'd4}) begin
            n_fail++; $display("FAIL full_after4: got full %b ovf %b count %0d want 1/0/4", sb_full, overflow, entry_count);
        end
        // Merge into the youngest while full: legal, no overflow.
        drive_store(1'b1, 32'h1018, 64'h77);
        tick();
        #1;
        n_cmp++; if ({overflow, entry_count} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL full_coalesce: got ovf %b count %0d want 0/4", overflow, entry_count);
        end
        drive_store(1'b1, 32'h1020, 64'h5);
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        #1;
        n_cmp++; if ({overflow, entry_count, sb_full} !== {1'b1, 3'd4, 1'b1}) begin
            n_fail++; $display("FAIL full_drop: got ovf %b count %0d full %b want 1/4/1", overflow, entry_count, sb_full);
        end
        // Push with a same-cycle pop into the full buffer.
        drive_store(1'b1, 32'h2000, 64'h55);
        drive_mem(1'b1, 4'd1);
        #1;
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_STORE, 32'h1000, 64'h1}) begin
            n_fail++; $display("FAIL full_pushpop_bus: got cmd %0d addr %h data %h want 2/1000/1", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        #1;
        n_cmp++; if ({entry_count, sb_full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL full_pushpop: got count %0d full %b ovf %b want 4/1/1", entry_count, sb_full, overflow);
        end
        exp_addr_q = '{32'h1008, 32'h1010, 32'h1018, 32'h2000};
        exp_data_q = '{64'h2, 64'h3, 64'h77, 64'h55};
        for (int c = 0; c < 12 && exp_addr_q.size() != 0; c++) begin
            if (proc2mem_command === BUS_STORE) begin
                n_cmp++; if ({proc2mem_addr, proc2mem_data} !== {exp_addr_q[0], exp_data_q[0]}) begin
                    n_fail++; $display("FAIL full_drain: got addr %h data %h want %h/%h", proc2mem_addr, proc2mem_data, exp_addr_q[0], exp_data_q[0]);
                end
                void'(exp_addr_q.pop_front());
                void'(exp_data_q.pop_front());
            end
            tick();
            #1;
        end
        n_cmp++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout: got %0d left want 0", exp_addr_q.size()); end
        n_cmp++; if ({sb_empty, fsm_state} !== {1'b1, S_IDLE}) begin
            n_fail++; $display("FAIL full_drain_end: got empty %b state %0d want 1/0", sb_empty, fsm_state);
        end
        drive_mem(1'b0, 4'd0);
    endtask

    task automatic test_retry();
        do_reset();
        drive_mem(1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            drive_store(1'b1, 32'h3000 + 32'(i * 8), 64'h31 + 64'(i));
            tick();
        end
        drive_store(1'b0, 32'h0, 64'h0);
        drive_mem(1'b1, 4'd0);
        #1;
        n_cmp++; if ({proc2mem_command, proc2mem_addr} !== {BUS_STORE, 32'h3000}) begin
            n_fail++; $display("FAIL retry_first: got cmd %0d addr %h want 2/3000", proc2mem_command, proc2mem_addr);
        end
        tick();
        #1;
        n_cmp++; if ({fsm_state, proc2mem_command} !== {S_BACKOFF, BUS_NONE}) begin
            n_fail++; $display("FAIL retry_backoff: got state %0d cmd %0d want 2/0", fsm_state, proc2mem_command);
        end
        tick();
        drive_mem(1'b1, 4'd1);
        #1;
        n_cmp++; if ({fsm_state, proc2mem_command, proc2mem_addr, proc2mem_data} !== {S_ISSUE, BUS_STORE, 32'h3000, 64'h31}) begin
            n_fail++; $display("FAIL retry_reissue: got state %0d cmd %0d addr %h data %h want 1/2/3000/31", fsm_state, proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        exp_addr_q = '{32'h3000, 32'h3008, 32'h3010};
        exp_data_q = '{64'h31, 64'h32, 64'h33};
        for (int c = 0; c < 10 && exp_addr_q.size() != 0; c++) begin
            if (proc2mem_command === BUS_STORE) begin
                n_cmp++; if ({proc2mem_addr, proc2mem_data} !== {exp_addr_q[0], exp_data_q[0]}) begin
                    n_fail++; $display("FAIL retry_order: got addr %h data %h want %h/%h", proc2mem_addr, proc2mem_data, exp_addr_q[0], exp_data_q[0]);
                end
                void'(exp_addr_q.pop_front());
                void'(exp_data_q.pop_front());
            end
            tick();
            #1;
        end
        n_cmp++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL retry_timeout: got %0d left want 0", exp_addr_q.size()); end
        drive_mem(1'b0, 4'd0);
    endtask

    task automatic test_fwd_priority();
        do_reset();
        drive_mem(1'b0, 4'd0);
        drive_store(1'b1, 32'h300, 64'h1);
        tick();
        drive_store(1'b1, 32'h308, 64'h2);
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        drive_probe(1'b1, 32'h304);
        #1;
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b1, 64'h1}) begin
            n_fail++; $display("FAIL fwd_entry: got hit %b data %h want 1/1", load_fwd_hit, load_fwd_data);
        end
        drive_probe(1'b0, 32'h304);
        #1;
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b0, 64'h0}) begin
            n_fail++; $display("FAIL fwd_gated: got hit %b data %h want 0/0", load_fwd_hit, load_fwd_data);
        end
        drive_store(1'b1, 32'h300, 64'h3);
        drive_probe(1'b1, 32'h304);
        #1;
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b1, 64'h3}) begin
            n_fail++; $display("FAIL fwd_incoming: got hit %b data %h want 1/3", load_fwd_hit, load_fwd_data);
        end
        drive_probe(1'b1, 32'h400);
        #1;
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b0, 64'h0}) begin
            n_fail++; $display("FAIL fwd_miss: got hit %b data %h want 0/0", load_fwd_hit, load_fwd_data);
        end
        tick();
        drive_store(1'b0, 32'h0, 64'h0);
        drive_probe(1'b1, 32'h300);
        #1;
        n_cmp++; if ({load_fwd_hit, load_fwd_data, entry_count} !== {1'b1, 64'h3, 3'd3}) begin
            n_fail++; $display("FAIL fwd_youngest: got hit %b data %h count %0d want 1/3/3", load_fwd_hit, load_fwd_data, entry_count);
        end
    endtask

    // Runs with the three entries left by test_fwd_priority, FSM in ISSUE.
    task automatic test_reset_mid_drain();
        n_cmp++; if ({fsm_state, entry_count} !== {S_ISSUE, 3'd3}) begin
            n_fail++; $display("FAIL rst_mid_pre: got state %0d count %0d want 1/3", fsm_state, entry_count);
        end
        drive_mem(1'b1, 4'd1);
        reset = 1'b1;
        #1;
        n_cmp++; if (proc2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rst_mid_same_cycle: got cmd %0d want 0", proc2mem_command); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if ({sb_empty, sb_full, overflow, entry_count, fsm_state} !== {1'b1, 1'b0, 1'b0, 3'd0, S_IDLE}) begin
            n_fail++; $display("FAIL rst_mid_flags: got empty %b full %b ovf %b count %0d state %0d want 1/0/0/0/0", sb_empty, sb_full, overflow, entry_count, fsm_state);
        end
        n_cmp++; if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_NONE, 32'd0, 64'd0}) begin
            n_fail++; $display("FAIL rst_mid_bus: got cmd %0d addr %h data %h want 0/0/0", proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        n_cmp++; if ({load_fwd_hit, load_fwd_data} !== {1'b0, 64'd0}) begin
            n_fail++; $display("FAIL rst_mid_fwd: got hit %b data %h want 0/0", load_fwd_hit, load_fwd_data);
        end
        drive_probe(1'b0, 32'h0);
        drive_mem(1'b0, 4'd0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        drive_store(1'b0, 32'h0, 64'h0);
        drive_probe(1'b0, 32'h0);
        drive_mem(1'b0, 4'd0);
        test_reset();
        test_basic_push();
        test_back_to_back();
        test_coalesce();
        test_full_overflow();
        test_retry();
        test_fwd_priority();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Dcache-side receiver for the dword stores emitted by the retire stage. Each `store_en` pulse delivers a full, already-merged 64-bit dword and its aligned address. The block queues these writes in a small FIFO and coalesces back-to-back writes to the same dword. It drains them in order to the memory bus under an arbiter grant, and forwards buffered data to younger loads so they never read stale memory.

## Interface
Parameters:
- `DEPTH`, 4: number of buffer entries, power of two, at least 2.
- `XLEN`, 32: address width.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `store_en`  in  1  retire is committing a store this cycle.
- `store2Dcache_addr`  in  XLEN  dword address; bits [2:0] are ignored and treated as 0.
- `store2Dcache_data`  in  64  full dword to write.
- `sb_full`  out  1  registered; high when the entry count equals DEPTH. Retire must hold stores while this is high.
- `sb_empty`  out  1  registered; high when the entry count is 0.
- `overflow`  out  1  sticky error flag; cleared only by reset.
- `load_lookup_valid`  in  1  a load is probing the buffer.
- `load_lookup_addr`  in  XLEN  load address; compared on bits [XLEN-1:3].
- `load_fwd_hit`  out  1  combinational; a matching dword is present.
- `load_fwd_data`  out  64  the matching dword; 0 when there is no hit.
- `mem_grant`  in  1  arbiter grants the memory bus to this block this cycle.
- `mem2proc_response`  in  4  non-zero means the memory accepted this cycle's command.
- `proc2mem_command`  out  2  BUS_STORE or BUS_NONE.
- `proc2mem_addr`  out  XLEN  head address with bits [2:0] = 0; 0 when idle.
- `proc2mem_data`  out  64  head data; 0 when idle.

## Operation
- The storage is a circular FIFO with head, tail and count. Each entry holds addr[XLEN-1:3] and data[63:0].
- Push: on `store_en`, the entry is written at the tail, the tail advances and the count increments.
- Coalesce: if the youngest valid entry has the same dword address as the incoming store, its data is overwritten and no entry is allocated. Coalescing is forbidden when that entry is the head and is being accepted by memory in the same cycle; in that case a normal push occurs instead.
- Full handling:
  - A push while the count equals DEPTH is accepted only if a pop occurs in the same cycle.
  - A push to a full buffer with no pop is dropped and sets `overflow`.
  - A coalesce into a full buffer is legal and does not set `overflow`.
- Drain FSM has three states: IDLE, ISSUE and BACKOFF.
  - IDLE: `proc2mem_command` = BUS_NONE. Go to ISSUE when the count is non-zero at the clock edge.
  - ISSUE with `mem_grant`=0: drive BUS_NONE and stay in ISSUE.
  - ISSUE with `mem_grant`=1: drive BUS_STORE with the head address and data.
    - If `mem2proc_response` is non-zero, pop the head. Go to IDLE if the count after the pop is 0; otherwise stay in ISSUE.
    - If `mem2proc_response` is 0, go to BACKOFF.
  - BACKOFF: drive BUS_NONE for exactly one cycle, then return to ISSUE.
- Forwarding considers all valid entries plus the incoming store in the same cycle (`store_en`). Priority is incoming store, then youngest entry, then oldest entry. `load_fwd_hit` is gated by `load_lookup_valid`.
- Pointers wrap modulo DEPTH. The count has $clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - FSM = IDLE; count, head and tail = 0.
  - `sb_full`=0, `sb_empty`=1, `overflow`=0.
  - `proc2mem_command`=BUS_NONE, `proc2mem_addr`=0, `proc2mem_data`=0.
  - `load_fwd_hit`=0, `load_fwd_data`=0.
- Reset mid-drain drops all entries and any in-flight command in the same cycle. Anything already accepted by memory stays written.
- Store latency: a push in cycle t puts BUS_STORE on the bus in cycle t+1 at the earliest, assuming IDLE and a grant.
- Drain throughput: one store per cycle under continuous grant with accepting responses.
- Push and pop may occur in the same cycle; the count is unchanged in that case.
- `sb_full` and `sb_empty` reflect the count after the edge.

## Test plan
- Basic push and drain:
  - Stimulus: reset; push addr 0x100, data 0x1122334455667788; `mem_grant`=1, response 1.
  - Required: cycle t+1 shows BUS_STORE, addr 0x100, that data. Then `sb_empty`=1, FSM=IDLE.
- Coalesce:
  - Stimulus: `mem_grant`=0; push 0x200/0xA, then 0x204/0xB.
  - Required: count=1. Forward probe at 0x200 gives hit, data 0xB.
  - Then grant: exactly one BUS_STORE, carrying data 0xB.
- Full and overflow:
  - Stimulus: `mem_grant`=0; push 5 distinct addresses.
  - Required: `sb_full`=1 after the 4th push; the 5th is dropped and `overflow`=1.
  - Stimulus: full buffer, then push with grant and response 1 in the same cycle.
  - Required: the push is accepted, count stays 4, `overflow` is unchanged.
- Retry:
  - Stimulus: ISSUE with grant and response 0.
  - Required: the next cycle is BACKOFF with BUS_NONE; the following cycle re-issues the same head. Order is preserved over 3 entries.
- Forwarding priority:
  - Stimulus: entries 0x300/0x1 and 0x308/0x2; same-cycle `store_en` 0x300/0x3; probe 0x304.
  - Required: `load_fwd_hit`=1, `load_fwd_data`=0x3.
  - Stimulus: probe 0x400.
  - Required: `load_fwd_hit`=0, `load_fwd_data`=0.
- Reset mid-drain:
  - Stimulus: assert reset with 3 entries queued during ISSUE.
  - Required: the next cycle has `sb_empty`=1, BUS_NONE, and all outputs at their reset values.
